// File: rtl/alu_issue_unit.sv
// Issue unit for the combinational ALU. It decodes one instruction, holds the ALU inputs steady
// while the ALU evaluates them, and then presents one writeback/branch record downstream.
module alu_issue_unit #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_instr_valid,
    output logic               o_instr_ready,
    input  logic [31:0]        i_instr,
    output logic [RADDR_W-1:0] o_rs_addr,
    output logic [RADDR_W-1:0] o_rt_addr,
    input  logic [XLEN-1:0]    i_rs_data,
    input  logic [XLEN-1:0]    i_rt_data,
    output logic [3:0]         o_alu_opcode,
    output logic [XLEN-1:0]    o_alu_wordA,
    output logic [XLEN-1:0]    o_alu_wordB,
    output logic [4:0]         o_alu_shamt,
    input  logic [XLEN-1:0]    i_alu_result,
    input  logic               i_alu_equal,
    input  logic               i_alu_notequal,
    output logic               o_wb_valid,
    input  logic               i_wb_ready,
    output logic               o_wb_we,
    output logic [RADDR_W-1:0] o_wb_rd,
    output logic [XLEN-1:0]    o_wb_data,
    output logic               o_wb_branch,
    output logic               o_wb_taken,
    output logic               o_wb_illegal
);

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

    state_t               state_q, state_d;
    logic [3:0]           opcode_q, opcode_d;
    logic [XLEN-1:0]      word_a_q, word_a_d;
    logic [XLEN-1:0]      word_b_q, word_b_d;
    logic [4:0]           shamt_q, shamt_d;
    logic [RADDR_W-1:0]   rd_q, rd_d;
    logic                 branch_q, branch_d;
    logic                 bne_q, bne_d;
    logic                 illegal_q, illegal_d;
    logic [XLEN-1:0]      data_q, data_d;
    logic                 taken_q, taken_d;

    logic [3:0]           dec_class;
    logic [13:0]          dec_imm;
    logic [3:0]           dec_opcode;
    logic [XLEN-1:0]      dec_word_a;
    logic [XLEN-1:0]      dec_word_b;
    logic [4:0]           dec_shamt;
    logic                 dec_branch;
    logic                 dec_illegal;

    assign o_rs_addr = i_instr[18:14];
    assign o_rt_addr = i_instr[13:9];
    assign dec_class = i_instr[31:28];
    assign dec_imm   = i_instr[13:0];

    always_comb begin
        dec_opcode  = i_instr[27:24];
        dec_word_a  = i_rs_data;
        dec_word_b  = i_rt_data;
        dec_shamt   = i_instr[8:4];
        dec_branch  = 1'b0;
        dec_illegal = 1'b0;
        case (dec_class)
            4'd0: ;
            4'd1: begin
                dec_word_b = {{(XLEN-14){dec_imm[13]}}, dec_imm};
                dec_shamt  = dec_imm[4:0];
            end
            4'd2: begin
                dec_word_b = {{(XLEN-14){1'b0}}, dec_imm};
                dec_shamt  = dec_imm[4:0];
            end
            4'd3: begin
                // Branches compare by subtraction; the ALU equality flags carry the decision.
                dec_opcode  = 4'h1;
                dec_shamt   = '0;
                dec_illegal = (i_instr[27:25] != 3'b000);
                dec_branch  = !dec_illegal;
            end
            default: begin
                dec_opcode  = '0;
                dec_word_a  = '0;
                dec_word_b  = '0;
                dec_shamt   = '0;
                dec_illegal = 1'b1;
            end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        word_a_d  = word_a_q;
        word_b_d  = word_b_q;
        shamt_d   = shamt_q;
        rd_d      = rd_q;
        branch_d  = branch_q;
        bne_d     = bne_q;
        illegal_d = illegal_q;
        data_d    = data_q;
        taken_d   = taken_q;
        case (state_q)
            IDLE: begin
                if (i_instr_valid) begin
                    opcode_d  = dec_opcode;
                    word_a_d  = dec_word_a;
                    word_b_d  = dec_word_b;
                    shamt_d   = dec_shamt;
                    rd_d      = i_instr[23:19];
                    branch_d  = dec_branch;
                    bne_d     = i_instr[24];
                    illegal_d = dec_illegal;
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                data_d  = illegal_q ? '0 : i_alu_result;
                taken_d = branch_q & (bne_q ? i_alu_notequal : i_alu_equal);
                state_d = WB;
            end
            WB: begin
                if (i_wb_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            opcode_q  <= '0;
            word_a_q  <= '0;
            word_b_q  <= '0;
            shamt_q   <= '0;
            rd_q      <= '0;
            branch_q  <= 1'b0;
            bne_q     <= 1'b0;
            illegal_q <= 1'b0;
            data_q    <= '0;
            taken_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            word_a_q  <= word_a_d;
            word_b_q  <= word_b_d;
            shamt_q   <= shamt_d;
            rd_q      <= rd_d;
            branch_q  <= branch_d;
            bne_q     <= bne_d;
            illegal_q <= illegal_d;
            data_q    <= data_d;
            taken_q   <= taken_d;
        end
    end

    assign o_instr_ready = (state_q == IDLE);
    assign o_wb_valid    = (state_q == WB);
    assign o_alu_opcode  = opcode_q;
    assign o_alu_wordA   = word_a_q;
    assign o_alu_wordB   = word_b_q;
    assign o_alu_shamt   = shamt_q;
    assign o_wb_we       = !illegal_q && !branch_q && (rd_q != '0);
    assign o_wb_rd       = rd_q;
    assign o_wb_data     = data_q;
    assign o_wb_branch   = branch_q;
    assign o_wb_taken    = taken_q;
    assign o_wb_illegal  = illegal_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit: a register file and ALU model surround the unit, and a
// decode-from-the-encoding reference predicts every record.
module tb_alu_issue_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        instrValid;
    logic        instrReady;
    logic [31:0] instr;
    logic [4:0]  rsAddr, rtAddr;
    logic [31:0] rsData, rtData;
    logic [3:0]  aluOpcode;
    logic [31:0] aluWordA, aluWordB, aluResult;
    logic [4:0]  aluShamt;
    logic        aluEqual, aluNotEqual;
    logic        wbValid, wbReady, wbWe, wbBranch, wbTaken, wbIllegal;
    logic [4:0]  wbRd;
    logic [31:0] wbData;

    logic [31:0] regs [32];
    int          passCount = 0;
    int          totalCount = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] aluRef(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [4:0] sh);
        case (op)
            4'h0: return a + b;
            4'h1: return a - b;
            4'h2: return a & b;
            4'h3: return a | b;
            4'h4: return a ^ b;
            4'h5: return a << sh;
            4'h6: return a >> sh;
            4'h7: return $signed(a) >>> sh;
            default: return a;
        endcase
    endfunction

    assign rsData      = regs[rsAddr];
    assign rtData      = regs[rtAddr];
    assign aluResult   = aluRef(aluOpcode, aluWordA, aluWordB, aluShamt);
    assign aluEqual    = (aluWordA == aluWordB);
    assign aluNotEqual = (aluWordA != aluWordB);

    alu_issue_unit dut (
        .i_clk(clk), .i_rst(rst),
        .i_instr_valid(instrValid), .o_instr_ready(instrReady), .i_instr(instr),
        .o_rs_addr(rsAddr), .o_rt_addr(rtAddr), .i_rs_data(rsData), .i_rt_data(rtData),
        .o_alu_opcode(aluOpcode), .o_alu_wordA(aluWordA), .o_alu_wordB(aluWordB),
        .o_alu_shamt(aluShamt), .i_alu_result(aluResult), .i_alu_equal(aluEqual),
        .i_alu_notequal(aluNotEqual), .o_wb_valid(wbValid), .i_wb_ready(wbReady),
        .o_wb_we(wbWe), .o_wb_rd(wbRd), .o_wb_data(wbData), .o_wb_branch(wbBranch),
        .o_wb_taken(wbTaken), .o_wb_illegal(wbIllegal)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        totalCount++;
        if (got === exp) passCount++;
        else $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    endtask

    // Issues one instruction, holds the record for holdCycles and checks every phase.
    task automatic applyStimulus(input logic [31:0] word, input int holdCycles);
        logic [3:0]  cls;
        logic [31:0] rsVal, rtVal, expA, expB, expData;
        logic [3:0]  expOp;
        logic [4:0]  expSh, expRd;
        logic        expIllegal, expBranch, expTaken, expWe;
        cls        = word[31:28];
        rsVal      = regs[word[18:14]];
        rtVal      = regs[word[13:9]];
        expRd      = word[23:19];
        expIllegal = (cls > 4'd3) || (cls == 4'd3 && word[27:25] != 3'b000);
        expBranch  = (cls == 4'd3) && !expIllegal;
        expOp      = (cls == 4'd3) ? 4'h1 : word[27:24];
        expA       = rsVal;
        if (cls == 4'd1)      expB = 32'($signed(word[13:0]));
        else if (cls == 4'd2) expB = {18'b0, word[13:0]};
        else                  expB = rtVal;
        expSh      = (cls == 4'd0) ? word[8:4] : word[4:0];
        expData    = expIllegal ? 32'd0 : aluRef(expOp, expA, expB, expSh);
        expTaken   = expBranch && (word[24] ? (rsVal != rtVal) : (rsVal == rtVal));
        expWe      = !expIllegal && !expBranch && (expRd != 5'd0);

        instr      = word;
        instrValid = 1'b1;
        checkOutput("ready_idle", 32'(instrReady), 32'd1);
        @(posedge clk); #1;
        instr = $urandom;
        checkOutput("ready_exec", 32'(instrReady), 32'd0);
        checkOutput("valid_exec", 32'(wbValid), 32'd0);
        if (!expIllegal) begin
            checkOutput("alu_opcode", 32'(aluOpcode), 32'(expOp));
            checkOutput("alu_wordA", aluWordA, expA);
            checkOutput("alu_wordB", aluWordB, expB);
            if (!expBranch) checkOutput("alu_shamt", 32'(aluShamt), 32'(expSh));
        end
        @(posedge clk); #1;
        for (int i = 0; i <= holdCycles; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
                instr = $urandom;
            end
            checkOutput("ready_wb", 32'(instrReady), 32'd0);
            checkOutput("wb_valid", 32'(wbValid), 32'd1);
            checkOutput("wb_we", 32'(wbWe), 32'(expWe));
            checkOutput("wb_rd", 32'(wbRd), 32'(expRd));
            checkOutput("wb_data", wbData, expData);
            checkOutput("wb_branch", 32'(wbBranch), 32'(expBranch));
            checkOutput("wb_taken", 32'(wbTaken), 32'(expTaken));
            checkOutput("wb_illegal", 32'(wbIllegal), 32'(expIllegal));
            if (!expIllegal) checkOutput("alu_hold", aluWordB, expB);
        end
        wbReady = 1'b1;
        @(posedge clk); #1;
        wbReady    = 1'b0;
        instrValid = 1'b0;
        checkOutput("valid_after_wb", 32'(wbValid), 32'd0);
        checkOutput("ready_after_wb", 32'(instrReady), 32'd1);
        if (expWe) regs[expRd] = expData;
    endtask

    // Asserts reset while an instruction is in EXEC (phase 0) or WB (phase 1).
    task automatic resetMidFlight(input int phase);
        instr      = {4'h0, 4'h0, 5'd3, 5'd1, 5'd2, 9'd0};
        instrValid = 1'b1;
        @(posedge clk); #1;
        instrValid = 1'b0;
        if (phase == 1) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        checkOutput("rst_wb_valid", 32'(wbValid), 32'd0);
        checkOutput("rst_ready", 32'(instrReady), 32'd1);
        checkOutput("rst_opcode_wordA", aluWordA | 32'(aluOpcode), 32'd0);
        checkOutput("rst_wordB_data", aluWordB | wbData, 32'd0);
        checkOutput("rst_flags", {27'd0, wbWe, wbBranch, wbTaken, wbIllegal, |wbRd}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("post_rst_ready", 32'(instrReady), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("post_rst_no_record", 32'(wbValid), 32'd0);
    endtask

    initial begin
        logic [31:0] word;
        rst = 1'b1; instrValid = 1'b0; instr = '0; wbReady = 1'b0;
        for (int r = 0; r < 32; r++) regs[r] = (r == 0) ? 32'd0 : $urandom;
        regs[1] = 32'd5; regs[2] = 32'd7; regs[9] = 32'd123; regs[10] = 32'd10;
        #2;
        checkOutput("reset_ready", 32'(instrReady), 32'd1);
        checkOutput("reset_wb_valid", 32'(wbValid), 32'd0);
        checkOutput("reset_data", wbData, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        applyStimulus({4'h0, 4'h0, 5'd3, 5'd1, 5'd2, 9'd0}, 0);
        applyStimulus({4'h1, 4'h1, 5'd4, 5'd10, 14'h3FFF}, 0);
        applyStimulus({4'h2, 4'h1, 5'd5, 5'd10, 14'h3FFF}, 0);
        applyStimulus({4'h3, 4'h1, 5'd0, 5'd9, 5'd9, 9'd0}, 1);
        applyStimulus({4'h3, 4'h0, 5'd0, 5'd9, 5'd9, 9'd0}, 0);
        applyStimulus({4'h7, 4'h5, 5'd6, 5'd1, 5'd2, 9'd0}, 0);
        applyStimulus({4'h3, 4'h2, 5'd6, 5'd1, 5'd2, 9'd0}, 0);
        applyStimulus({4'h0, 4'h0, 5'd0, 5'd1, 5'd2, 9'd0}, 5);
        resetMidFlight(0);
        resetMidFlight(1);

        for (int n = 0; n < 150; n++) begin
            word = $urandom;
            word[31:28] = 4'($urandom_range(0, 5));
            if (word[31:28] == 4'd3 && $urandom_range(0, 3) != 0) word[27:25] = 3'b000;
            if ($urandom_range(0, 3) == 0) word[13:9] = word[18:14];
            applyStimulus(word, $urandom_range(0, 3));
        end

        $display("[TB] %0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
